// File: rtl/fhe_delay_line_pkg.sv
// Shared types and constants for the FHE ALU delay line.
package fhe_delay_line_pkg;

    localparam int unsigned FSIZE               = 32;
    localparam int unsigned FHE_DLY_MAX_DEFAULT = 16;

    typedef logic [FSIZE-1:0] lane_word_t;

endpackage

// File: rtl/fhe_delay_line_if.sv
// Valid-tagged sample stream into and out of the delay line.
interface fhe_delay_line_if
    import fhe_delay_line_pkg::*;
#(
    parameter int unsigned LANES     = 4,
    parameter int unsigned DATA_SIZE = FSIZE
);

    logic                         in_valid;
    logic [LANES*DATA_SIZE-1:0]   in_data;
    logic                         out_valid;
    logic [LANES*DATA_SIZE-1:0]   out_data;

    modport master (
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/fhe_delay_line_ring_mem.sv
// Register ring of DEPTH entries; MSB of each entry is the valid tag.
// One write port, one combinational read port, bulk tag clear.
module delay_ring_mem
    import fhe_delay_line_pkg::*;
#(
    parameter int unsigned DEPTH = FHE_DLY_MAX_DEFAULT,
    parameter int unsigned WIDTH = 4 * FSIZE + 1,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             clr_tags,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Tag clear and write are never requested together by the owner.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
            if (clr_tags) begin
                mem_d[i][WIDTH-1] = 1'b0;
            end
        end
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fhe_delay_line.sv
// Multi-lane programmable delay line: circular ring, stall, flush and delay reload.
// Output is a mux of ring registers selected by registered pointer and delay.
module fhe_delay_line
    import fhe_delay_line_pkg::*;
#(
    parameter int unsigned DATA_SIZE     = FSIZE,
    parameter int unsigned LANES         = 4,
    parameter int unsigned MAX_DELAY     = FHE_DLY_MAX_DEFAULT,
    parameter int unsigned DEFAULT_DELAY = 2,
    parameter int unsigned DLY_W         = $clog2(MAX_DELAY + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic               flush,
    input  logic               cfg_load,
    input  logic [DLY_W-1:0]   cfg_delay,
    fhe_delay_line_if.slave    bus,
    output logic [DLY_W-1:0]   delay_active,
    output logic [DLY_W-1:0]   occupancy,
    output logic               cfg_err
);

    localparam int unsigned DW    = LANES * DATA_SIZE;
    localparam int unsigned EW    = DW + 1;
    localparam int unsigned PTR_W = $clog2(MAX_DELAY);
    localparam int unsigned SUM_W = DLY_W + 1;

    logic [PTR_W-1:0] wptr_q,    wptr_d;
    logic [DLY_W-1:0] delay_q,   delay_d;
    logic [DLY_W-1:0] occ_q,     occ_d;
    logic             cfg_err_q, cfg_err_d;

    logic             ring_we;
    logic             ring_clr;
    logic [PTR_W-1:0] rd_idx;
    logic [SUM_W-1:0] rd_sum;
    logic [EW-1:0]    rd_entry;
    logic             dly_legal;
    logic             cfg_ok;

    assign dly_legal = (cfg_delay != '0) && (cfg_delay <= DLY_W'(MAX_DELAY));
    assign cfg_ok    = cfg_load && dly_legal;

    // Read slot is (wptr - D) mod MAX_DELAY; D == MAX_DELAY lands on the write slot.
    always_comb begin
        rd_sum = SUM_W'(wptr_q) + SUM_W'(MAX_DELAY) - SUM_W'(delay_q);
        if (rd_sum >= SUM_W'(MAX_DELAY)) begin
            rd_idx = PTR_W'(rd_sum - SUM_W'(MAX_DELAY));
        end else begin
            rd_idx = PTR_W'(rd_sum);
        end
    end

    // Priority: legal reload, then flush, then enabled advance.
    always_comb begin
        wptr_d    = wptr_q;
        delay_d   = delay_q;
        occ_d     = occ_q;
        cfg_err_d = cfg_load && !dly_legal;
        ring_we   = 1'b0;
        ring_clr  = 1'b0;
        if (cfg_ok) begin
            delay_d  = cfg_delay;
            occ_d    = '0;
            ring_clr = 1'b1;
        end else if (flush) begin
            occ_d    = '0;
            ring_clr = 1'b1;
        end else if (en) begin
            ring_we = 1'b1;
            wptr_d  = (wptr_q == PTR_W'(MAX_DELAY - 1)) ? '0 : wptr_q + PTR_W'(1);
            occ_d   = occ_q + DLY_W'(bus.in_valid) - DLY_W'(rd_entry[EW-1]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q    <= '0;
            delay_q   <= DLY_W'(DEFAULT_DELAY);
            occ_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            delay_q   <= delay_d;
            occ_q     <= occ_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    delay_ring_mem #(
        .DEPTH (MAX_DELAY),
        .WIDTH (EW),
        .AW    (PTR_W)
    ) u_ring (
        .clk      (clk),
        .rstn     (rstn),
        .we       (ring_we),
        .waddr    (wptr_q),
        .wdata    ({bus.in_valid, bus.in_data}),
        .clr_tags (ring_clr),
        .raddr    (rd_idx),
        .rdata    (rd_entry)
    );

    assign bus.out_valid = rd_entry[EW-1];
    assign bus.out_data  = rd_entry[DW-1:0];
    assign delay_active  = delay_q;
    assign occupancy     = occ_q;
    assign cfg_err       = cfg_err_q;

endmodule
